rom_rd_arbiter: RTL and testbench

Round-robin read arbiter that shares one `rom_1port` instance between two independent requesters. Each requester presents an address with a request/grant handshake. The arbiter drives the ROM address, tracks which requester owns each in-flight read through a latency-matched tag pipeline, and returns ROM data to the owner with a one-cycle valid strobe. It sits directly in front of `rom_1port` in the ROM demo top level and replaces the free-running address counter.

---
 rtl/rom_ctrl_pkg.sv | 18 +
 rtl/rom_rd_arbiter_if.sv | 36 +++
 rtl/rr_arb2.sv | 38 +++
 rtl/rom_rd_arbiter.sv | 87 ++++++++
 tb/tb_rom_rd_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_ctrl_pkg.sv
// Shared definitions for the ROM read path: requester ids, default widths and
// the ROM read latency that the tag pipeline must match.
package rom_ctrl_pkg;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    // rom_1port is configured with registered address and registered output
    localparam int RD_LAT_DEF = 2;

    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

endpackage

// File: rtl/rom_rd_arbiter_if.sv
// Two-requester read bus plus the ROM-facing address/data pair.
interface rom_rd_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              iws_req0;
    logic [ADDR_W-1:0] iwv_addr0;
    logic              ows_gnt0;
    logic              ows_vld0;
    logic [DATA_W-1:0] owv_data0;

    logic              iws_req1;
    logic [ADDR_W-1:0] iwv_addr1;
    logic              ows_gnt1;
    logic              ows_vld1;
    logic [DATA_W-1:0] owv_data1;

    logic [ADDR_W-1:0] owv_rom_addr;
    logic [DATA_W-1:0] iwv_rom_q;
    logic              ows_busy;

    // requesters and the ROM model sit on the master side
    modport master (
        output iws_req0, iwv_addr0, iws_req1, iwv_addr1, iwv_rom_q,
        input  ows_gnt0, ows_vld0, owv_data0,
        input  ows_gnt1, ows_vld1, owv_data1,
        input  owv_rom_addr, ows_busy
    );

    modport slave (
        input  iws_req0, iwv_addr0, iws_req1, iwv_addr1, iwv_rom_q,
        output ows_gnt0, ows_vld0, owv_data0,
        output ows_gnt1, ows_vld1, owv_data1,
        output owv_rom_addr, ows_busy
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; r_pri names the requester that wins a tie and
// flips to the other side after every grant.
module rr_arb2
    import rom_ctrl_pkg::*;
(
    input  logic iws_clk,
    input  logic iws_rst_n,
    input  logic iws_req0,
    input  logic iws_req1,
    output logic ows_gnt0,
    output logic ows_gnt1
);

    logic r_pri;

    always_comb begin
        ows_gnt0 = 1'b0;
        ows_gnt1 = 1'b0;
        if (iws_rst_n) begin
            if (iws_req0 && (!iws_req1 || r_pri == REQ0)) begin
                ows_gnt0 = 1'b1;
            end else if (iws_req1) begin
                ows_gnt1 = 1'b1;
            end
        end
    end

    always_ff @(posedge iws_clk) begin
        if (!iws_rst_n) begin
            r_pri <= REQ0;
        end else if (ows_gnt0) begin
            r_pri <= REQ1;
        end else if (ows_gnt1) begin
            r_pri <= REQ0;
        end
    end

endmodule

// File: rtl/rom_rd_arbiter.sv
// Shares one rom_1port between two requesters; a tag pipeline matched to the
// ROM latency steers each returning word back to the requester that issued it.
module rom_rd_arbiter
    import rom_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic             iws_clk,
    input  logic             iws_rst_n,
    rom_rd_arbiter_if.slave  bus
);

    localparam int LAST = RD_LAT - 1;

    logic              gnt_any;
    logic              gnt_id;
    logic [ADDR_W-1:0] gnt_addr;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;
    tag_t              r_tag [RD_LAT];
    logic              ret_vld0;
    logic              ret_vld1;
    logic              busy;

    rr_arb2 u_arb (
        .iws_clk   (iws_clk),
        .iws_rst_n (iws_rst_n),
        .iws_req0  (bus.iws_req0),
        .iws_req1  (bus.iws_req1),
        .ows_gnt0  (bus.ows_gnt0),
        .ows_gnt1  (bus.ows_gnt1)
    );

    assign gnt_any  = bus.ows_gnt0 | bus.ows_gnt1;
    assign gnt_id   = bus.ows_gnt1 ? REQ1 : REQ0;
    assign gnt_addr = bus.ows_gnt1 ? bus.iwv_addr1 : bus.iwv_addr0;

    // holding the last address keeps the ROM input quiet while idle
    assign bus.owv_rom_addr = gnt_any ? gnt_addr : r_addr_hold;

    assign ret_vld0 = r_tag[LAST].vld && (r_tag[LAST].id == REQ0);
    assign ret_vld1 = r_tag[LAST].vld && (r_tag[LAST].id == REQ1);

    always_ff @(posedge iws_clk) begin
        if (!iws_rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag[i] <= '0;
            end
            r_addr_hold <= '0;
            r_data0     <= '0;
            r_data1     <= '0;
        end else begin
            r_tag[0].vld <= gnt_any;
            r_tag[0].id  <= gnt_id;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            if (gnt_any) begin
                r_addr_hold <= gnt_addr;
            end
            if (ret_vld0) begin
                r_data0 <= bus.iwv_rom_q;
            end
            if (ret_vld1) begin
                r_data1 <= bus.iwv_rom_q;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            busy = busy | r_tag[i].vld;
        end
    end

    // returning word is visible in its vld cycle and then held by the register
    assign bus.ows_vld0  = ret_vld0;
    assign bus.ows_vld1  = ret_vld1;
    assign bus.owv_data0 = ret_vld0 ? bus.iwv_rom_q : r_data0;
    assign bus.owv_data1 = ret_vld1 ? bus.iwv_rom_q : r_data1;
    assign bus.ows_busy  = busy;

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// Randomised and directed bench for rom_rd_arbiter with a 2-cycle ROM model
// (q = addr ^ 8'hA5) and a queue-based reference of round-robin arbitration.
module tb_rom_rd_arbiter;

    logic clk;
    logic rst_n;

    rom_rd_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    rom_rd_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) dut (
        .iws_clk   (clk),
        .iws_rst_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] rom_p1;
    logic [7:0] rom_p2;
    always @(posedge clk) begin
        rom_p1 <= bus.owv_rom_addr;
        rom_p2 <= rom_p1 ^ 8'hA5;
    end
    assign bus.iwv_rom_q = rom_p2;

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       m_pri = 1'b0;
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_d0 = 8'h00;
    logic [7:0] m_d1 = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // reference model and scoreboard, evaluated mid-cycle
    always @(negedge clk) begin
        logic       eg0, eg1, ebusy;
        logic [7:0] eaddr;
        exp_t       e;
        cyc++;
        ebusy = (q0.size() != 0) || (q1.size() != 0);
        check("busy", bus.ows_busy, ebusy);

        if (q0.size() != 0 && q0[0].due == cyc) begin
            e = q0.pop_front();
            check("vld0", bus.ows_vld0, 1'b1);
            check("data0", bus.owv_data0, e.data);
            m_d0 = e.data;
        end else begin
            check("vld0", bus.ows_vld0, 1'b0);
            check("data0_hold", bus.owv_data0, m_d0);
        end
        if (q1.size() != 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            check("vld1", bus.ows_vld1, 1'b1);
            check("data1", bus.owv_data1, e.data);
            m_d1 = e.data;
        end else begin
            check("vld1", bus.ows_vld1, 1'b0);
            check("data1_hold", bus.owv_data1, m_d1);
        end

        eg0 = 1'b0;
        eg1 = 1'b0;
        if (rst_n) begin
            if (bus.iws_req0 && bus.iws_req1) begin
                if (m_pri) eg1 = 1'b1;
                else       eg0 = 1'b1;
            end else if (bus.iws_req0) begin
                eg0 = 1'b1;
            end else if (bus.iws_req1) begin
                eg1 = 1'b1;
            end
        end
        eaddr = eg0 ? bus.iwv_addr0 : (eg1 ? bus.iwv_addr1 : m_addr);
        check("gnt0", bus.ows_gnt0, eg0);
        check("gnt1", bus.ows_gnt1, eg1);
        check("rom_addr", bus.owv_rom_addr, eaddr);

        if (!rst_n) begin
            q0.delete();
            q1.delete();
            m_pri  = 1'b0;
            m_addr = 8'h00;
            m_d0   = 8'h00;
            m_d1   = 8'h00;
        end else if (eg0) begin
            q0.push_back('{due: cyc + 2, data: bus.iwv_addr0 ^ 8'hA5});
            m_addr = bus.iwv_addr0;
            m_pri  = 1'b1;
        end else if (eg1) begin
            q1.push_back('{due: cyc + 2, data: bus.iwv_addr1 ^ 8'hA5});
            m_addr = bus.iwv_addr1;
            m_pri  = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic [7:0] a0, input logic r1, input logic [7:0] a1);
        bus.iws_req0  = r0;
        bus.iwv_addr0 = a0;
        bus.iws_req1  = r1;
        bus.iwv_addr1 = a1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int         n;
        int         bound;
        logic [7:0] a;
        logic       act0, act1, g0, g1;
        logic [7:0] ra0, ra1;

        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        step();
        step();
        rst_n = 1'b1;

        // single read
        drive(1'b1, 8'h10, 1'b0, 8'h00);
        step();
        idle(4);

        // contention straight after reset
        do_reset();
        drive(1'b1, 8'h01, 1'b1, 8'h02);
        repeat (4) step();
        idle(4);

        // streaming on requester 1, address advances on each grant
        n = 0;
        a = 8'h00;
        bound = 0;
        while (n < 256 && bound < 600) begin
            drive(1'b0, 8'h00, 1'b1, a);
            @(negedge clk);
            if (bus.ows_gnt1) begin
                n++;
                a++;
            end
            bound++;
            step();
        end
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL stream_grants: got %0d expected 256", n);
        end
        idle(4);

        // priority hold: requester 0 alone, then both
        drive(1'b1, 8'h40, 1'b0, 8'h00);
        repeat (3) step();
        drive(1'b1, 8'h41, 1'b1, 8'h51);
        repeat (2) step();
        idle(4);

        // reset with a read in flight
        drive(1'b0, 8'h00, 1'b1, 8'h20);
        step();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(3);
        drive(1'b1, 8'h03, 1'b1, 8'h04);
        repeat (2) step();
        idle(4);

        // idle hold after last grant
        drive(1'b1, 8'h33, 1'b0, 8'h00);
        step();
        idle(6);

        // random traffic with occasional drops and resets
        act0 = 1'b0;
        act1 = 1'b0;
        ra0 = 8'h00;
        ra1 = 8'h00;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            g0 = bus.ows_gnt0;
            g1 = bus.ows_gnt1;
            step();
            if (act0 && g0) act0 = 1'b0;
            if (act1 && g1) act1 = 1'b0;
            if (!act0 && ($urandom % 3) == 0) begin
                act0 = 1'b1;
                ra0  = 8'($urandom);
            end else if (act0 && ($urandom % 16) == 0) begin
                act0 = 1'b0;
            end
            if (!act1 && ($urandom % 3) == 0) begin
                act1 = 1'b1;
                ra1  = 8'($urandom);
            end else if (act1 && ($urandom % 16) == 0) begin
                act1 = 1'b0;
            end
            rst_n = (($urandom % 150) != 0);
            if (!rst_n) begin
                act0 = 1'b0;
                act1 = 1'b0;
            end
            drive(act0, ra0, act1, ra1);
        end
        rst_n = 1'b1;
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
